// File: rtl/hyperspectral_hw_mul_share_arb_if.sv
// rtl/hyperspectral_hw_mul_share_arb_if.sv - requester operand and product channels of the shared multiplier
interface hyperspectral_hw_mul_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 19,
  parameter int B_W     = 8,
  parameter int P_W     = 19
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     rsp_valid;
  logic [NUM_REQ-1:0]     rsp_ready;
  logic [P_W-1:0]         rsp_p;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_p
  );
endinterface

// File: rtl/hyperspectral_hw_mul_share_arb.sv
// rtl/hyperspectral_hw_mul_share_arb.sv - round-robin sharing of one pipelined multiplier core among requesters
module hyperspectral_hw_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int A_W     = 19,
  parameter int B_W     = 8,
  parameter int P_W     = 19,
  parameter int LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  hyperspectral_hw_mul_share_arb_if.slave   bus,
  output logic                              mul_ce,
  output logic [A_W-1:0]                    mul_din0,
  output logic [B_W-1:0]                    mul_din1,
  input  logic [P_W-1:0]                    mul_dout,
  output logic                              busy
);

  logic [LATENCY-1:0] vld_pipe;
  logic [TAG_W-1:0]   tag_pipe [LATENCY];
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   grant;
  logic [TAG_W-1:0]   grant_nxt;
  logic               any_req;
  logic               issue;
  logic               stall;
  logic               vld_tail;
  logic [TAG_W-1:0]   tag_tail;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] rsp_valid;

  assign vld_tail = vld_pipe[LATENCY-1];
  assign tag_tail = tag_pipe[LATENCY-1];

  // The tail stage lines up with mul_dout, so an unaccepted product freezes the whole core.
  assign stall  = vld_tail & ~bus.rsp_ready[tag_tail];
  assign mul_ce = reset | ~stall;

  always_comb begin
    int idx;
    idx     = 0;
    grant   = rr_ptr;
    any_req = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!any_req && bus.req_valid[idx]) begin
        grant   = TAG_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign issue     = any_req & mul_ce & ~reset;
  assign grant_nxt = (int'(grant) == NUM_REQ - 1) ? '0 : grant + TAG_W'(1);

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = vld_tail & ~reset & (tag_tail == TAG_W'(i));
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_p     = mul_dout;

  assign mul_din0 = bus.req_a[int'(grant)*A_W +: A_W];
  assign mul_din1 = bus.req_b[int'(grant)*B_W +: B_W];
  assign busy     = |vld_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      rr_ptr   <= '0;
    end else if (mul_ce) begin
      vld_pipe[0] <= issue;
      for (int i = 1; i < LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (issue) rr_ptr <= grant_nxt;
    end
  end

  // Tags need no reset: a cleared vld_pipe masks whatever they hold.
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      tag_pipe[0] <= grant;
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_hyperspectral_hw_mul_share_arb.sv
// tb/tb_hyperspectral_hw_mul_share_arb.sv - directed vector bench for the shared multiplier arbiter
module tb_hyperspectral_hw_mul_share_arb;

  localparam logic [18:0] P0 = 19'h0012C;  // 100 * 3
  localparam logic [18:0] P1 = 19'h7FC18;  // -5 * 200 = -1000
  localparam logic [18:0] P2 = 19'h40000;  // -262144 * 255, low 19 bits
  localparam logic [18:0] P3 = 19'h3FFFF;  // 262143 * 1

  typedef struct {
    logic        rst_before;
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  rr;
    logic [3:0]  e_ready;
    logic        e_ce;
    logic [3:0]  e_rsp_valid;
    logic [18:0] e_p;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_ce;
  logic [18:0] mul_din0;
  logic [7:0]  mul_din1;
  logic [18:0] mul_dout;
  logic        busy;

  logic [18:0] c0, c1, c2;
  logic [18:0] a_op [4];
  logic [7:0]  b_op [4];
  vec_t        vq [$];
  vec_t        v;
  int          checks = 0;
  int          errors = 0;
  int          idx;

  hyperspectral_hw_mul_share_arb_if #(.NUM_REQ(4), .A_W(19), .B_W(8), .P_W(19)) bus ();

  hyperspectral_hw_mul_share_arb #(
    .NUM_REQ(4), .TAG_W(2), .A_W(19), .B_W(8), .P_W(19), .LATENCY(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .mul_ce   (mul_ce),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] core_mul(input logic [18:0] a, input logic [7:0] b);
    logic signed [31:0] p;
    p = $signed({{13{a[18]}}, a}) * $signed({24'd0, b});
    return p[18:0];
  endfunction

  // Three-stage core without reset, advancing only on ce.
  always @(posedge clk) begin
    if (mul_ce) begin
      c0 <= core_mul(mul_din0, mul_din1);
      c1 <= c0;
      c2 <= c1;
    end
  end
  assign mul_dout = c2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    #1;
    chk("rst_mul_ce", {31'd0, mul_ce}, 32'd1);
    chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_rsp_valid", {28'd0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic add(input logic rb, input logic rs, input logic [3:0] rv, input logic [3:0] rr,
                     input logic [3:0] er, input logic ec, input logic [3:0] erv,
                     input logic [18:0] ep, input logic eb);
    vq.push_back('{rb, rs, rv, rr, er, ec, erv, ep, eb});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    a_op = '{19'd100, 19'h7FFFB, 19'h40000, 19'h3FFFF};
    b_op = '{8'd3, 8'd200, 8'd255, 8'd1};
    for (int k = 0; k < 4; k++) begin
      bus.req_a[k*19 +: 19] = a_op[k];
      bus.req_b[k*8 +: 8]   = b_op[k];
    end

    // single shot from requester 1
    add(1, 0, 4'b0010, 4'hF, 4'b0010, 1, 4'b0000, 19'd0, 0);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0010, P1,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 0);
    // full contention, eight issues
    add(1, 0, 4'b1111, 4'hF, 4'b0001, 1, 4'b0000, 19'd0, 0);
    add(0, 0, 4'b1111, 4'hF, 4'b0010, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b1111, 4'hF, 4'b0100, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b1111, 4'hF, 4'b1000, 1, 4'b0001, P0,    1);
    add(0, 0, 4'b1111, 4'hF, 4'b0001, 1, 4'b0010, P1,    1);
    add(0, 0, 4'b1111, 4'hF, 4'b0010, 1, 4'b0100, P2,    1);
    add(0, 0, 4'b1111, 4'hF, 4'b0100, 1, 4'b1000, P3,    1);
    add(0, 0, 4'b1111, 4'hF, 4'b1000, 1, 4'b0001, P0,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0010, P1,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0100, P2,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b1000, P3,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 0);
    // backpressure on requester 2 for five cycles
    add(1, 0, 4'b0110, 4'hF, 4'b0010, 1, 4'b0000, 19'd0, 0);
    add(0, 0, 4'b0110, 4'hF, 4'b0100, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0110, 4'hF, 4'b0010, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0110, 4'hF, 4'b0100, 1, 4'b0010, P1,    1);
    for (int s = 0; s < 5; s++) add(0, 0, 4'b0110, 4'b1011, 4'b0000, 0, 4'b0100, P2, 1);
    add(0, 0, 4'b0110, 4'hF, 4'b0010, 1, 4'b0100, P2,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0010, P1,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0100, P2,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0010, P1,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 0);
    // reset with three products in flight, then a fresh request
    add(1, 0, 4'b1111, 4'hF, 4'b0001, 1, 4'b0000, 19'd0, 0);
    add(0, 0, 4'b1111, 4'hF, 4'b0010, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b1111, 4'hF, 4'b0100, 1, 4'b0000, 19'd0, 1);
    add(0, 1, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b1000, 4'hF, 4'b1000, 1, 4'b0000, 19'd0, 0);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b1000, P3,    1);
    add(0, 0, 4'b0000, 4'hF, 4'b0000, 1, 4'b0000, 19'd0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      if (v.rst_before) do_reset();
      @(negedge clk);
      reset = v.rst;
      bus.req_valid = v.rv;
      bus.rsp_ready = v.rr;
      #1;
      chk($sformatf("v%0d req_ready", i), {28'd0, bus.req_ready}, {28'd0, v.e_ready});
      chk($sformatf("v%0d mul_ce", i), {31'd0, mul_ce}, {31'd0, v.e_ce});
      chk($sformatf("v%0d rsp_valid", i), {28'd0, bus.rsp_valid}, {28'd0, v.e_rsp_valid});
      chk($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, v.e_busy});
      if (v.e_rsp_valid != 4'd0)
        chk($sformatf("v%0d rsp_p", i), {13'd0, bus.rsp_p}, {13'd0, v.e_p});
      if (v.e_ready != 4'd0) begin
        idx = 0;
        for (int k = 0; k < 4; k++) if (v.e_ready[k]) idx = k;
        chk($sformatf("v%0d din0", i), {13'd0, mul_din0}, {13'd0, a_op[idx]});
        chk($sformatf("v%0d din1", i), {24'd0, mul_din1}, {24'd0, b_op[idx]});
      end
    end
    reset = 1'b0;

    // sparse: requester 3 alone, every fourth cycle
    do_reset();
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        bus.req_valid = (c == 0) ? 4'b1000 : 4'b0000;
        bus.rsp_ready = 4'hF;
        #1;
        chk($sformatf("sparse%0d.%0d mul_ce", n, c), {31'd0, mul_ce}, 32'd1);
        if (c == 0)
          chk($sformatf("sparse%0d req_ready", n), {28'd0, bus.req_ready}, 32'h8);
        if (c == 1)
          chk($sformatf("sparse%0d rr_ptr", n), {30'd0, dut.rr_ptr}, 32'd0);
        if (c == 3) begin
          chk($sformatf("sparse%0d rsp_valid", n), {28'd0, bus.rsp_valid}, 32'h8);
          chk($sformatf("sparse%0d rsp_p", n), {13'd0, bus.rsp_p}, {13'd0, P3});
        end else begin
          chk($sformatf("sparse%0d.%0d rsp_idle", n, c), {28'd0, bus.rsp_valid}, 32'd0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
